// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for four FIFO writers.
// Owner keeps the grant until MAX_BURST words land or it drops req.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              req,
  input  logic [4*DATA_WIDTH-1:0] din,
  input  logic                    fifo_full,
  output logic [3:0]              gnt,
  output logic [3:0]              ack,
  output logic                    fifo_wr,
  output logic [DATA_WIDTH-1:0]   fifo_wdata,
  output logic                    busy
);

  localparam int CW = $clog2(MAX_BURST);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state;
  logic [1:0]    rr_ptr;
  logic [1:0]    owner;
  logic [CW-1:0] count;
  logic [1:0]    win;
  logic          last_word;
  logic          drop;

  // Word handshake: only the owner can be acked, never into a full FIFO.
  always_comb begin
    ack        = gnt & req & {4{~fifo_full}};
    fifo_wr    = |ack;
    fifo_wdata = din[32'(owner)*DATA_WIDTH +: DATA_WIDTH];
    last_word  = fifo_wr && (count == CW'(MAX_BURST - 1));
    drop       = !req[owner];
  end

  // First requester at or after rr_ptr, wrapping mod 4.
  always_comb begin
    win = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr + 2'(k)]) begin
        win = rr_ptr + 2'(k);
      end
    end
  end

  // Two-state burst FSM with registered grant and busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      gnt    <= '0;
      busy   <= 1'b0;
      rr_ptr <= '0;
      owner  <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= BURST;
            gnt   <= 4'b0001 << win;
            owner <= win;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        BURST: begin
          if (drop || last_word) begin
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            count  <= '0;
            rr_ptr <= owner + 2'd1;
          end else if (fifo_wr) begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus randomized
// protocol/fairness checker for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      req = '0;
  logic [4*DW-1:0] din = 32'h4332_2110;
  logic            fifo_full = 1'b0;
  logic [3:0]      gnt;
  logic [3:0]      ack;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_wdata;
  logic            busy;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .din       (din),
    .fifo_full (fifo_full),
    .gnt       (gnt),
    .ack       (ack),
    .fifo_wr   (fifo_wr),
    .fifo_wdata(fifo_wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       busy;
    logic [7:0] wdata;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nfail = 0;

  function automatic logic [7:0] word(input logic [3:0] a);
    logic [7:0] w;
    w = 8'h00;
    if (a[0]) w = 8'h10;
    if (a[1]) w = 8'h21;
    if (a[2]) w = 8'h32;
    if (a[3]) w = 8'h43;
    return w;
  endfunction

  function automatic void add(input logic r, input logic [3:0] q,
                              input logic f, input logic [3:0] g,
                              input logic [3:0] a, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.full = f;
    v.gnt = g; v.ack = a; v.busy = b;
    v.wdata = word(a);
    tbl.push_back(v);
  endfunction

  function automatic void burst(input logic [3:0] q, input logic [3:0] g,
                                input int n);
    for (int i = 0; i < n; i++) add(1, q, 0, g, g, 1);
  endfunction

  logic [3:0] last_gnt;
  logic [3:0] nreq;
  int         wt[4];
  int         blen;
  logic [3:0] owners[6] = '{4'b1000, 4'b0001, 4'b0010,
                            4'b0100, 4'b1000, 4'b0001};

  initial begin
    // reset held, then owner 1 from 1010, idle gap, owner 3
    add(0, 4'b1010, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b1010, 0, 4'b0000, 4'b0000, 0);
    burst(4'b1010, 4'b0010, 4);
    add(1, 4'b1010, 0, 4'b0000, 4'b0000, 0);
    burst(4'b1010, 4'b1000, 1);
    // three full cycles stall owner 3
    for (int i = 0; i < 3; i++) add(1, 4'b1010, 1, 4'b1000, 4'b0000, 1);
    burst(4'b1010, 4'b1000, 3);
    // owner 2 drops after 2 words -> rr_ptr 3
    add(1, 4'b0100, 0, 4'b0000, 4'b0000, 0);
    burst(4'b0100, 4'b0100, 2);
    add(1, 4'b0000, 0, 4'b0100, 4'b0000, 1);
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b1111, 0, 4'b0000, 4'b0000, 0);
    // all requesting: rotation 3,0,1,2,3,0
    for (int o = 0; o < 6; o++) begin
      burst(4'b1111, owners[o], 4);
      add(1, 4'b1111, 0, 4'b0000, 4'b0000, 0);
    end
    // owner 1 granted but not requesting -> drop, rr_ptr 2
    add(1, 4'b1000, 0, 4'b0010, 4'b0000, 1);
    add(1, 4'b1000, 0, 4'b0000, 4'b0000, 0);
    burst(4'b1000, 4'b1000, 1);
    // async reset mid-burst, then index 0 wins from 1001
    add(0, 4'b1000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1001, 0, 4'b0000, 4'b0000, 0);
    add(1, 4'b1001, 0, 4'b0000, 4'b0000, 0);
    burst(4'b1001, 4'b0001, 1);
    burst(4'b0001, 4'b0001, 3);
    // same requester re-wins only after an idle cycle
    add(1, 4'b0001, 0, 4'b0000, 4'b0000, 0);
    burst(4'b0001, 4'b0001, 1);

    foreach (tbl[k]) begin
      @(negedge clk);
      reset = tbl[k].rst;
      req = tbl[k].req;
      fifo_full = tbl[k].full;
      #1;
      nvec++;
      if (gnt !== tbl[k].gnt || ack !== tbl[k].ack ||
          fifo_wr !== (|tbl[k].ack) || busy !== tbl[k].busy ||
          ((|tbl[k].ack) && fifo_wdata !== tbl[k].wdata)) begin
        nfail++;
        $display("FAIL vec%0d: got gnt=%b ack=%b wr=%b busy=%b wdata=%h, want gnt=%b ack=%b wr=%b busy=%b wdata=%h",
                 k, gnt, ack, fifo_wr, busy, fifo_wdata,
                 tbl[k].gnt, tbl[k].ack, |tbl[k].ack, tbl[k].busy,
                 tbl[k].wdata);
      end
    end

    // randomized traffic with invariant and fairness checks
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    last_gnt = '0;
    blen = 0;
    for (int i = 0; i < 4; i++) wt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      #1;
      nvec++;
      if (!$onehot0(gnt) || !$onehot0(ack) || (ack & ~gnt) != 4'b0 ||
          (fifo_wr && fifo_full) || fifo_wr != (|ack) ||
          (gnt != 4'b0 && last_gnt != 4'b0 && gnt != last_gnt)) begin
        nfail++;
        $display("FAIL rand_proto c%0d: gnt=%b ack=%b wr=%b full=%b prev_gnt=%b, want one-hot grant/ack, no write while full",
                 c, gnt, ack, fifo_wr, fifo_full, last_gnt);
      end
      if (gnt == 4'b0) blen = 0;
      else if (fifo_wr) blen++;
      nvec++;
      if (blen > 4) begin
        nfail++;
        $display("FAIL rand_burst c%0d: burst length %0d, want <= 4", c, blen);
      end
      if (gnt != 4'b0 && last_gnt == 4'b0) begin
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) wt[i] = 0;
          else if (req[i]) wt[i]++;
        end
        nvec++;
        if (wt[0] > 4 || wt[1] > 4 || wt[2] > 4 || wt[3] > 4) begin
          nfail++;
          $display("FAIL rand_fair c%0d: waits %0d %0d %0d %0d, want <= 4",
                   c, wt[0], wt[1], wt[2], wt[3]);
        end
      end
      nreq = req;
      for (int i = 0; i < 4; i++) begin
        if (req[i] && last_gnt[i] && !gnt[i]) nreq[i] = 1'b0;
        else if (gnt[i] && $urandom_range(0, 15) == 0) nreq[i] = 1'b0;
        else if (!req[i]) nreq[i] = ($urandom_range(0, 2) == 0);
        if (!nreq[i]) wt[i] = 0;
      end
      last_gnt = gnt;
      req = nreq;
      fifo_full = ($urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
